pingpong_frame_reader: RTL and testbench

//  Read-side consumer for the ping-pong RAM buffer. Waits for the buffer's one-cycle

---
 rtl/fpga_template_pkg.sv | 11 +
 rtl/stream_out_reg.sv | 65 ++++++
 rtl/pingpong_frame_reader.sv | 182 ++++++++++++++++++
 tb/tb_pingpong_frame_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_template_pkg.sv
// Shared types and constants for the ping-pong frame reader.
package fpga_template_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } reader_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register carrying {data, first, last}.
// The writer must only push while in_ready_o is high.
module stream_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    input  logic signed [WIDTH-1:0] in_data_i,
    input  logic                    in_first_i,
    input  logic                    in_last_i,
    output logic                    in_ready_o,
    output logic                    out_valid_o,
    output logic signed [WIDTH-1:0] out_data_o,
    output logic                    out_first_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i
);

    logic                    valid_q, valid_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;

    assign in_ready_o = !valid_q || out_ready_i;

    // Load on push, empty when the consumer takes the word, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        first_d = first_q;
        last_d  = last_q;
        if (in_valid_i) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            first_d = in_first_i;
            last_d  = in_last_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_first_o = first_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/pingpong_frame_reader.sv
// Drains one DEPTH-word frame per buffer frame-ready pulse into a framed stream.
// Optional frame XOR checksum: define PINGPONG_READER_CHECKSUM_EN.
module pingpong_frame_reader
    import fpga_template_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    buf_frame_rdy_i,
    input  logic signed [WIDTH-1:0] buf_data_i,
    input  logic                    buf_valid_i,
    output logic                    buf_ready_o,
    output logic signed [WIDTH-1:0] m_data_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_first_o,
    output logic                    m_last_o,
    output logic                    frame_done_o,
    output logic                    frame_err_o,
    output logic [FRAME_CNT_W-1:0]  frame_count_o,
    output logic                    busy_o,
    output logic [WIDTH-1:0]        checksum_o
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [IDLE_W-1:0]     IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES - 1);

    reader_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   out_ready_s;
    logic                   buf_hs_s;
    logic                   is_last_s;
    logic                   push_s;
    logic                   clr_s;

    assign buf_ready_o = (state_q == DRAIN) && out_ready_s;
    assign buf_hs_s    = buf_valid_i && buf_ready_o;
    assign is_last_s   = (word_cnt_q == LAST_WORD);

    // Frame FSM: a frame-ready pulse that does not coincide with the last word is an overrun.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        push_s      = 1'b0;
        clr_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_frame_rdy_i) begin
                    state_d    = DRAIN;
                    word_cnt_d = ADDR_WIDTH'(0);
                    idle_cnt_d = IDLE_W'(0);
                    clr_s      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (buf_frame_rdy_i && !(buf_hs_s && is_last_s)) begin
                    err_d      = 1'b1;
                    word_cnt_d = ADDR_WIDTH'(0);
                    idle_cnt_d = IDLE_W'(0);
                    clr_s      = 1'b1;
                end else if (buf_hs_s) begin
                    push_s     = 1'b1;
                    idle_cnt_d = IDLE_W'(0);
                    if (is_last_s) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                        word_cnt_d  = ADDR_WIDTH'(0);
                        state_d     = buf_frame_rdy_i ? DRAIN : IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                    end
                end else if (idle_cnt_q == IDLE_MAX) begin
                    err_d      = 1'b1;
                    state_d    = IDLE;
                    word_cnt_d = ADDR_WIDTH'(0);
                    idle_cnt_d = IDLE_W'(0);
                    clr_s      = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counters and status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            word_cnt_q  <= ADDR_WIDTH'(0);
            idle_cnt_q  <= IDLE_W'(0);
            frame_cnt_q <= FRAME_CNT_W'(0);
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    stream_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (push_s),
        .in_data_i   (buf_data_i),
        .in_first_i  (word_cnt_q == ADDR_WIDTH'(0)),
        .in_last_i   (is_last_s),
        .in_ready_o  (out_ready_s),
        .out_valid_o (m_valid_o),
        .out_data_o  (m_data_o),
        .out_first_o (m_first_o),
        .out_last_o  (m_last_o),
        .out_ready_i (m_ready_i)
    );

    assign frame_done_o  = done_q;
    assign frame_err_o   = err_q;
    assign frame_count_o = frame_cnt_q;
    assign busy_o        = (state_q == DRAIN);

`ifdef PINGPONG_READER_CHECKSUM_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] csum_q, csum_d;

    // Running XOR; published only when the last word of a frame is accepted.
    always_comb begin
        acc_d  = acc_q;
        csum_d = csum_q;
        if (clr_s) begin
            acc_d = {WIDTH{1'b0}};
        end else if (push_s && is_last_s) begin
            csum_d = acc_q ^ buf_data_i;
            acc_d  = {WIDTH{1'b0}};
        end else if (push_s) begin
            acc_d = acc_q ^ buf_data_i;
        end else begin
            acc_d = acc_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= {WIDTH{1'b0}};
            csum_q <= {WIDTH{1'b0}};
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end

    assign checksum_o = csum_q;
`else
    logic unused_clr_s;
    assign unused_clr_s = clr_s;
    assign checksum_o   = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pingpong_frame_reader.sv
// Randomized bench for pingpong_frame_reader against a cycle-level behavioural model.
module tb_pingpong_frame_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int TMO   = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    buf_frame_rdy;
    logic signed [WIDTH-1:0] buf_data;
    logic                    buf_valid;
    logic                    buf_ready;
    logic signed [WIDTH-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_first;
    logic                    m_last;
    logic                    frame_done;
    logic                    frame_err;
    logic [15:0]             frame_count;
    logic                    busy;
    logic [WIDTH-1:0]        checksum;

    always #5 clk = ~clk;

    pingpong_frame_reader #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .buf_frame_rdy_i (buf_frame_rdy),
        .buf_data_i      (buf_data),
        .buf_valid_i     (buf_valid),
        .buf_ready_o     (buf_ready),
        .m_data_o        (m_data),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .m_first_o       (m_first),
        .m_last_o        (m_last),
        .frame_done_o    (frame_done),
        .frame_err_o     (frame_err),
        .frame_count_o   (frame_count),
        .busy_o          (busy),
        .checksum_o      (checksum)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        l;
    } item_t;

    item_t       mdl_outq[$];
    bit          mdl_in_frame;
    int          mdl_words;
    int          mdl_idle;
    int          mdl_frames;
    bit          mdl_done;
    bit          mdl_err;
    logic [31:0] mdl_acc;
    logic [31:0] mdl_csum;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_outq.delete();
        mdl_in_frame = 1'b0;
        mdl_words    = 0;
        mdl_idle     = 0;
        mdl_frames   = 0;
        mdl_done     = 1'b0;
        mdl_err      = 1'b0;
        mdl_acc      = 32'h0;
        mdl_csum     = 32'h0;
    endtask

    task automatic check_outputs(input bit mr);
        bit exp_ready;
        exp_ready = mdl_in_frame && (mdl_outq.size() == 0 || mr);
        check_eq("buf_ready", 32'(buf_ready), 32'(exp_ready));
        check_eq("m_valid", 32'(m_valid), 32'(mdl_outq.size() != 0));
        if (mdl_outq.size() != 0) begin
            check_eq("m_data", m_data, mdl_outq[0].d);
            check_eq("m_first", 32'(m_first), 32'(mdl_outq[0].f));
            check_eq("m_last", 32'(m_last), 32'(mdl_outq[0].l));
        end
        check_eq("frame_done", 32'(frame_done), 32'(mdl_done));
        check_eq("frame_err", 32'(frame_err), 32'(mdl_err));
        check_eq("frame_count", 32'(frame_count), 32'(mdl_frames & 16'hFFFF));
        check_eq("busy", 32'(busy), 32'(mdl_in_frame));
`ifdef PINGPONG_READER_CHECKSUM_EN
        check_eq("checksum", checksum, mdl_csum);
`else
        check_eq("checksum", checksum, 32'h0);
`endif
    endtask

    // Applies the frame rules for one clock period given this cycle's inputs.
    task automatic model_step(input bit fr, input bit v, input logic [31:0] d, input bit mr,
                              output bit hs);
        bit ready;
        bit last;
        ready    = mdl_in_frame && (mdl_outq.size() == 0 || mr);
        hs       = v && ready;
        last     = (mdl_words == DEPTH - 1);
        mdl_done = 1'b0;
        mdl_err  = 1'b0;
        if (mdl_outq.size() != 0 && mr) void'(mdl_outq.pop_front());
        if (!mdl_in_frame) begin
            if (fr) begin
                mdl_in_frame = 1'b1;
                mdl_words    = 0;
                mdl_idle     = 0;
                mdl_acc      = 32'h0;
            end
        end else if (fr && !(hs && last)) begin
            mdl_err   = 1'b1;
            mdl_words = 0;
            mdl_idle  = 0;
            mdl_acc   = 32'h0;
        end else if (hs) begin
            mdl_outq.push_back('{d: d, f: (mdl_words == 0), l: last});
            mdl_acc  = mdl_acc ^ d;
            mdl_idle = 0;
            if (last) begin
                mdl_done     = 1'b1;
                mdl_frames   = mdl_frames + 1;
                mdl_csum     = mdl_acc;
                mdl_acc      = 32'h0;
                mdl_words    = 0;
                mdl_in_frame = fr;
            end else begin
                mdl_words++;
            end
        end else begin
            mdl_idle++;
            if (mdl_idle == TMO) begin
                mdl_err      = 1'b1;
                mdl_in_frame = 1'b0;
                mdl_words    = 0;
                mdl_idle     = 0;
                mdl_acc      = 32'h0;
            end
        end
    endtask

    task automatic tick(input bit fr, input bit v, input logic [31:0] d, input bit mr,
                        output bit hs);
        buf_frame_rdy = fr;
        buf_valid     = v;
        buf_data      = d;
        m_ready       = mr;
        @(negedge clk);
        check_outputs(mr);
        if (rst) begin
            model_reset();
            hs = 1'b0;
        end else begin
            model_step(fr, v, d, mr, hs);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        bit hs;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 1'b1, hs);
    endtask

    // rmode: 0 ready always, 1 ready toggling, 2 ready random.
    task automatic feed(input int nwords, input int stop_at, input int repulse_at,
                        input int vpct, input int rmode, input bit seq, input int base,
                        input bit coincide, input bit start);
        int          w;
        int          cyc;
        bit          hs, fr, v, mr, repulsed;
        logic [31:0] d;
        w        = 0;
        repulsed = 1'b0;
        d        = seq ? 32'(base) : $urandom;
        if (start) tick(1'b1, 1'b0, 32'h0, 1'b1, hs);
        for (cyc = 0; cyc < 400 && w < nwords; cyc++) begin
            mr = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(1));
            v  = (w < stop_at) && ($urandom_range(99) < vpct);
            fr = 1'b0;
            if (repulse_at >= 0 && !repulsed && w == repulse_at) begin
                fr       = 1'b1;
                repulsed = 1'b1;
            end
            if (coincide && w == DEPTH - 1 && v) fr = 1'b1;
            tick(fr, v, d, mr, hs);
            if (fr && !(coincide && w == DEPTH - 1)) w = 0;
            else if (hs) w++;
            if (hs || fr) d = seq ? 32'(base + w) : $urandom;
        end
        if (w < nwords) check_eq("feed_budget", 32'(w), 32'(nwords));
    endtask

    initial begin
        bit hs;
        rst           = 1'b1;
        buf_frame_rdy = 1'b0;
        buf_valid     = 1'b0;
        buf_data      = '0;
        m_ready       = 1'b0;
        model_reset();
        tick(1'b0, 1'b0, 32'h0, 1'b0, hs);
        tick(1'b0, 1'b0, 32'h0, 1'b1, hs);
        rst = 1'b0;

        // Words 0..15, full throughput, then alternating downstream stall.
        feed(16, 16, -1, 100, 0, 1'b1, 0, 1'b0, 1'b1);
        idle_cycles(4);
        check_eq("count_after_first", 32'(frame_count), 32'd1);
        feed(16, 16, -1, 100, 1, 1'b1, 0, 1'b0, 1'b1);
        idle_cycles(4);

        // Buffer stalls after 5 words: timeout, count unchanged.
        feed(5, 5, -1, 100, 0, 1'b1, 100, 1'b0, 1'b1);
        idle_cycles(TMO + 4);
        check_eq("count_after_timeout", 32'(frame_count), 32'd2);

        // Overrun after word 7, then a full new frame.
        feed(16, 16, 7, 100, 0, 1'b1, 200, 1'b0, 1'b1);
        idle_cycles(4);

        // Reset mid-frame after 9 words.
        feed(9, 16, -1, 100, 0, 1'b1, 300, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("rst_m_valid", 32'(m_valid), 32'h0);
        check_eq("rst_m_data", m_data, 32'h0);
        check_eq("rst_first_last", {30'h0, m_first, m_last}, 32'h0);
        check_eq("rst_status", {29'h0, frame_done, frame_err, busy}, 32'h0);
        check_eq("rst_count", 32'(frame_count), 32'h0);
        check_eq("rst_buf_ready", 32'(buf_ready), 32'h0);
        check_eq("rst_checksum", checksum, 32'h0);
        model_reset();
        tick(1'b0, 1'b0, 32'h0, 1'b1, hs);
        rst = 1'b0;

        // Words 1..16: XOR is 0x10.
        feed(16, 16, -1, 100, 0, 1'b1, 1, 1'b0, 1'b1);
        idle_cycles(3);
`ifdef PINGPONG_READER_CHECKSUM_EN
        check_eq("checksum_1_to_16", checksum, 32'h10);
`endif

        // Frame-ready coincident with the last handshake: no error, new frame then times out.
        feed(16, 16, -1, 100, 0, 1'b0, 0, 1'b1, 1'b1);
        idle_cycles(TMO + 4);

        // Random gaps, random stalls, random data, occasional overrun.
        for (int f = 0; f < 20; f++) begin
            feed(16, 16, ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1,
                 75, 2, 1'b0, 0, 1'b0, 1'b1);
            idle_cycles(3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
